combat_damage_scheduler: RTL

//  Sequences per-tick combat resolution. On each combat tick it snapshots which friendly units and which enemies

---
 rtl/combat_damage_scheduler.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/combat_damage_scheduler.sv
// Per-tick combat resolution sequencer: snapshots attack requests on tick, then grants one attacker
// per channel per cycle in round-robin order and drives the damage decoder select/damage inputs.
module combat_damage_scheduler #(
    parameter int N_ATK = 16,
    parameter int SEL_W = 5,
    parameter int DMG_W = 9
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     tick,
    input  logic [N_ATK-1:0]         friendlyAtkReq,
    input  logic [N_ATK*SEL_W-1:0]   friendlyTarget,
    input  logic [N_ATK*DMG_W-1:0]   friendlyDamage,
    input  logic [N_ATK-1:0]         friendlyCrit,
    input  logic [N_ATK-1:0]         enemyAtkReq,
    input  logic [N_ATK*SEL_W-1:0]   enemyTarget,
    input  logic [N_ATK*DMG_W-1:0]   enemyDamage,
    input  logic [N_ATK-1:0]         enemyCrit,
    output logic [SEL_W-1:0]         enemyDamageSelect,
    output logic [DMG_W-1:0]         totalEnemyDamage,
    output logic [SEL_W-1:0]         unitDamageSelect,
    output logic [DMG_W-1:0]         totalUnitDamage,
    output logic                     busy,
    output logic                     roundDone,
    output logic                     tickMissed
);

    localparam int PTR_W = $clog2(N_ATK);
    localparam logic [SEL_W-1:0] SEL_IDLE = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N_ATK-1:0]   pend_f_q, pend_f_d;
    logic [N_ATK-1:0]   pend_e_q, pend_e_d;
    logic [PTR_W-1:0]   ptr_f_q, ptr_f_d;
    logic [PTR_W-1:0]   ptr_e_q, ptr_e_d;
    logic [SEL_W-1:0]   enemy_sel_q, enemy_sel_d;
    logic [DMG_W-1:0]   enemy_dmg_q, enemy_dmg_d;
    logic [SEL_W-1:0]   unit_sel_q, unit_sel_d;
    logic [DMG_W-1:0]   unit_dmg_q, unit_dmg_d;
    logic               tick_missed_q, tick_missed_d;

    logic               found_f, found_e;
    logic [PTR_W-1:0]   idx_f, idx_e;

    // Rotate the mask so ptr sits at bit 0, take the lowest set bit, then rotate the index back.
    function automatic logic [PTR_W:0] rr_pick(input logic [N_ATK-1:0] pend,
                                                input logic [PTR_W-1:0] ptr);
        logic [2*N_ATK-1:0] dbl;
        logic [N_ATK-1:0]   rot;
        logic               hit;
        logic [PTR_W-1:0]   off;
        dbl = {pend, pend} >> ptr;
        rot = dbl[N_ATK-1:0];
        hit = 1'b0;
        off = '0;
        for (int i = N_ATK - 1; i >= 0; i--) begin
            if (rot[i]) begin
                hit = 1'b1;
                off = PTR_W'(i);
            end
        end
        return {hit, off + ptr};
    endfunction

    function automatic logic [DMG_W-1:0] hit_damage(input logic [DMG_W-1:0] dmg, input logic crit);
        logic [DMG_W:0] dbl;
        dbl = {dmg, 1'b0};
        if (!crit) begin
            return dmg;
        end
        return dbl[DMG_W] ? {DMG_W{1'b1}} : dbl[DMG_W-1:0];
    endfunction

    assign {found_f, idx_f} = rr_pick(pend_f_q, ptr_f_q);
    assign {found_e, idx_e} = rr_pick(pend_e_q, ptr_e_q);

    always_comb begin
        state_d       = state_q;
        pend_f_d      = pend_f_q;
        pend_e_d      = pend_e_q;
        ptr_f_d       = ptr_f_q;
        ptr_e_d       = ptr_e_q;
        enemy_sel_d   = SEL_IDLE;
        enemy_dmg_d   = '0;
        unit_sel_d    = SEL_IDLE;
        unit_dmg_d    = '0;
        tick_missed_d = tick && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    pend_f_d = friendlyAtkReq;
                    pend_e_d = enemyAtkReq;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                // The cycle after the last grant shows idle outputs, so DONE follows the final hit.
                if ((pend_f_q == '0) && (pend_e_q == '0)) begin
                    state_d = ST_DONE;
                end
                if (found_f) begin
                    pend_f_d[idx_f] = 1'b0;
                    ptr_f_d         = idx_f + 1'b1;
                    enemy_sel_d     = friendlyTarget[SEL_W*int'(idx_f) +: SEL_W];
                    enemy_dmg_d     = hit_damage(friendlyDamage[DMG_W*int'(idx_f) +: DMG_W],
                                                 friendlyCrit[idx_f]);
                end
                if (found_e) begin
                    pend_e_d[idx_e] = 1'b0;
                    ptr_e_d         = idx_e + 1'b1;
                    unit_sel_d      = enemyTarget[SEL_W*int'(idx_e) +: SEL_W];
                    unit_dmg_d      = hit_damage(enemyDamage[DMG_W*int'(idx_e) +: DMG_W],
                                                 enemyCrit[idx_e]);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= ST_IDLE;
            pend_f_q      <= '0;
            pend_e_q      <= '0;
            ptr_f_q       <= '0;
            ptr_e_q       <= '0;
            enemy_sel_q   <= SEL_IDLE;
            enemy_dmg_q   <= '0;
            unit_sel_q    <= SEL_IDLE;
            unit_dmg_q    <= '0;
            tick_missed_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_f_q      <= pend_f_d;
            pend_e_q      <= pend_e_d;
            ptr_f_q       <= ptr_f_d;
            ptr_e_q       <= ptr_e_d;
            enemy_sel_q   <= enemy_sel_d;
            enemy_dmg_q   <= enemy_dmg_d;
            unit_sel_q    <= unit_sel_d;
            unit_dmg_q    <= unit_dmg_d;
            tick_missed_q <= tick_missed_d;
        end
    end

    assign enemyDamageSelect = enemy_sel_q;
    assign totalEnemyDamage  = enemy_dmg_q;
    assign unitDamageSelect  = unit_sel_q;
    assign totalUnitDamage   = unit_dmg_q;
    assign busy              = (state_q != ST_IDLE);
    assign roundDone         = (state_q == ST_DONE);
    assign tickMissed        = tick_missed_q;

endmodule
